probe_dump: RTL and testbench
=============================

PROBE_DUMP -- requirements
Module: probe_dump

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 16, giving the number of probe channels (>=1).
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the bits per channel (multiple of 4, >=4).
REQ-003 The block SHALL have parameter LINE_PER_CH, default 1: 1 = CR LF after every channel; 0 = space between channels and a single CR LF at the end.
REQ-004 The block SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port start  input  1  dump request, sampled on rising clk.
REQ-007 The block SHALL have port chan  input  NUM_CH*WIDTH  flattened probes; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port d_tx  output  8  ASCII byte to the UART transmitter.
REQ-009 The block SHALL have port vld_tx  output  1  d_tx valid.
REQ-010 The block SHALL have port rdy_tx  input  1  transmitter ready; a byte transfers on a rising edge with vld_tx&&rdy_tx.
REQ-011 The block SHALL have port busy  output  1  dump in progress.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-013 start while busy=0 SHALL snapshot all of chan into an internal register on that edge; later chan changes SHALL NOT affect the stream.
REQ-014 start SHALL set busy=1 and vld_tx=1 on the same edge; the first byte is the MSB nibble of channel 0.
REQ-015 Channels SHALL be emitted in order 0..NUM_CH-1; each channel SHALL be emitted as WIDTH/4 hex digits, MSB nibble first.
REQ-016 Nibble 0-9 SHALL map to 0x30-0x39, and nibble A-F SHALL map to uppercase 0x41-0x46.
REQ-017 The FSM SHALL have states IDLE, HEX, SEP, CR and LF; transitions SHALL occur only on a transfer, except IDLE->HEX on start.
REQ-018 HEX SHALL advance through the digits; after the last digit of a channel it SHALL go to CR if LINE_PER_CH=1 or if the channel is the last, and otherwise to SEP (byte 0x20).
REQ-019 SEP->HEX of the next channel; CR (0x0D)->LF; LF (0x0A)->HEX of the next channel, or IDLE if the channel was the last.
REQ-020 Byte count per dump SHALL be NUM_CH*(WIDTH/4+2) for LINE_PER_CH=1, and NUM_CH*(WIDTH/4)+NUM_CH+1 for LINE_PER_CH=0.
REQ-021 While vld_tx=1 and rdy_tx=0, d_tx SHALL be held stable and vld_tx SHALL stay 1.
REQ-022 d_tx and vld_tx SHALL be registered; after a non-final transfer the next byte SHALL be presented on the same edge, with no idle cycle.
REQ-023 On the edge that transfers the final LF, the block SHALL set vld_tx=0, busy=0 and done=1; done SHALL drop on the next edge.
REQ-024 start while busy=1, including the final-transfer edge, SHALL be ignored; a new dump requires start with busy=0.
REQ-025 Channel and nibble counters SHALL be sized to ceil(log2) of NUM_CH and WIDTH/4 (minimum 1 bit) and SHALL reset to 0 at each dump start, without wrapping mid-dump.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, counters 0, snapshot 0, d_tx=0x00, vld_tx=0, busy=0 and done=0.
REQ-027 rst asserted mid-dump SHALL abandon the stream with no further bytes; after release, start SHALL begin again at channel 0, digit 0.
REQ-028 start SHALL be ignored while rst=1.

Verification
REQ-029 Defaults, chan0=0x0000ABCD, rdy_tx=1 -> first bytes 30 30 30 30 41 42 43 44 0D 0A; 160 bytes total; done pulses once; busy=0 afterwards.
REQ-030 Defaults, rdy_tx=0 for 5 cycles while byte 3 is presented -> d_tx and vld_tx=1 stay constant for those cycles, with no byte lost or duplicated.
REQ-031 Set chan0=0x12345678, start, then chan0=0xFFFFFFFF on the next cycle -> stream begins 31 32 33 34 35 36 37 38.
REQ-032 NUM_CH=2, WIDTH=8, LINE_PER_CH=0, chans 0x1F and 0xA0 -> exactly 31 46 20 41 30 0D 0A, then done.
REQ-033 rst pulsed after byte 5 -> vld_tx=0 and busy=0 immediately; a subsequent start restarts at channel 0 digit 0.
REQ-034 start reasserted every cycle during a dump -> byte count unchanged and only one done pulse; start after done -> a second full dump.

Source files
------------

// File: rtl/probe_dump.sv
// Hex dump of a bank of probe channels as an ASCII byte stream for a UART transmitter.
// Channels are snapshotted at start and emitted MSB nibble first with CR/LF or space separators.
module probe_dump #(
  parameter int NUM_CH      = 16,
  parameter int WIDTH       = 32,
  parameter int LINE_PER_CH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_CH*WIDTH-1:0] chan,
  output logic [7:0]              d_tx,
  output logic                    vld_tx,
  input  logic                    rdy_tx,
  output logic                    busy,
  output logic                    done
);

  localparam int NIB   = WIDTH / 4;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIB - 1);

  typedef enum logic [2:0] {IDLE, HEX, SEP, CR, LF} state_t;

  state_t                  state, state_n;
  logic [CH_W-1:0]         ch, ch_n;
  logic [NIB_W-1:0]        nib, nib_n;
  logic [NUM_CH*WIDTH-1:0] snap, src;
  logic [WIDTH-1:0]        word;
  logic [3:0]              digit;
  logic [7:0]              d_n;
  logic                    xfer, last_ch, done_n;
  int unsigned             wbase, nbase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ch     <= '0;
      nib    <= '0;
      snap   <= '0;
      d_tx   <= '0;
      vld_tx <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      ch     <= ch_n;
      nib    <= nib_n;
      d_tx   <= d_n;
      vld_tx <= (state_n != IDLE);
      busy   <= (state_n != IDLE);
      done   <= done_n;
      if (state == IDLE && start)
        snap <= chan;
    end
  end

  always_comb begin
    state_n = state;
    ch_n    = ch;
    nib_n   = nib;
    done_n  = 1'b0;
    xfer    = vld_tx && rdy_tx;
    last_ch = (ch == LAST_CH);
    case (state)
      IDLE: if (start) begin
        state_n = HEX;
        ch_n    = '0;
        nib_n   = '0;
      end
      HEX: if (xfer) begin
        if (nib == LAST_NIB) begin
          nib_n   = '0;
          state_n = (LINE_PER_CH != 0 || last_ch) ? CR : SEP;
        end else begin
          nib_n = nib + 1'b1;
        end
      end
      SEP: if (xfer) begin
        state_n = HEX;
        ch_n    = ch + 1'b1;
      end
      CR: if (xfer) state_n = LF;
      LF: if (xfer) begin
        if (last_ch) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = HEX;
          ch_n    = ch + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The byte for the next state is precomputed so d_tx is registered; on the
  // start edge the snapshot is not loaded yet, so the live inputs are used.
  always_comb begin
    src   = (state == IDLE) ? chan : snap;
    wbase = 32'(ch_n) * 32'(WIDTH);
    nbase = (32'(LAST_NIB) - 32'(nib_n)) * 32'd4;
    word  = WIDTH'(src >> wbase);
    digit = 4'(word >> nbase);
    case (state_n)
      HEX:     d_n = (digit < 4'd10) ? (8'h30 + {4'h0, digit}) : (8'h37 + {4'h0, digit});
      SEP:     d_n = 8'h20;
      CR:      d_n = 8'h0D;
      LF:      d_n = 8'h0A;
      default: d_n = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_probe_dump.sv
// Randomized bench for probe_dump: default-parameter instance plus a 2x8-bit space-separated instance.
module tb_probe_dump;

  localparam int NCH = 16;
  localparam int W   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, rdy_tx, vld_tx, busy, done;
  logic [NCH*W-1:0] chan;
  logic [7:0]       d_tx;

  logic        s_start, s_rdy, s_vld, s_busy, s_done;
  logic [15:0] s_chan;
  logic [7:0]  s_d;

  probe_dump #(.NUM_CH(NCH), .WIDTH(W), .LINE_PER_CH(1)) dut (
    .clk(clk), .rst(rst), .start(start), .chan(chan), .d_tx(d_tx),
    .vld_tx(vld_tx), .rdy_tx(rdy_tx), .busy(busy), .done(done)
  );

  probe_dump #(.NUM_CH(2), .WIDTH(8), .LINE_PER_CH(0)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .chan(s_chan), .d_tx(s_d),
    .vld_tx(s_vld), .rdy_tx(s_rdy), .busy(s_busy), .done(s_done)
  );

  int passed = 0;
  int total  = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int dones, stall_cycles, stall_bad, gaps;

  // Reference: ASCII hex of each channel, MSB nibble first, then separators.
  task automatic build_exp(input logic [511:0] s, input int nch, input int w, input bit line);
    logic [511:0] t;
    int n;
    exp_q.delete();
    for (int k = 0; k < nch; k++) begin
      for (int d = 0; d < w / 4; d++) begin
        t = s >> (k * w + w - 4 * (d + 1));
        n = int'(t[3:0]);
        exp_q.push_back(8'(n < 10 ? 48 + n : 65 + (n - 10)));
      end
      if (line || k == nch - 1) begin
        exp_q.push_back(8'd13);
        exp_q.push_back(8'd10);
      end else begin
        exp_q.push_back(8'd32);
      end
    end
  endtask

  function automatic int first_diff();
    if (got.size() != exp_q.size()) return -2;
    foreach (got[i]) if (got[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic logic [NCH*W-1:0] rand_chan();
    logic [NCH*W-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*W +: W] = $urandom;
    return v;
  endfunction

  task automatic kick(input logic [NCH*W-1:0] v);
    @(negedge clk);
    chan  = v;
    start = 1'b1;
  endtask

  // mode 0: always ready; 1: random ready; 2: five forced stalls on the fourth byte
  task automatic collect(input int mode, input bit hold_start, input bit scramble, input int max_cycles);
    bit stalled = 1'b0;
    logic [7:0] prev = '0;
    int forced = 0;
    got.delete();
    dones = 0; stall_cycles = 0; stall_bad = 0; gaps = 0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      start = hold_start;
      if (scramble) chan = '1;
      if (done === 1'b1) begin
        dones++;
        start  = 1'b0;
        rdy_tx = 1'b1;
        break;
      end
      if (stalled) begin
        stall_cycles++;
        if (vld_tx !== 1'b1 || d_tx !== prev) stall_bad++;
      end
      if (vld_tx === 1'b1) begin
        case (mode)
          0: rdy_tx = 1'b1;
          1: rdy_tx = ($urandom_range(0, 2) != 0);
          default: begin
            if (got.size() == 3 && forced < 5) begin
              rdy_tx = 1'b0;
              forced++;
            end else rdy_tx = 1'b1;
          end
        endcase
        if (rdy_tx) got.push_back(d_tx);
        stalled = !rdy_tx;
        prev    = d_tx;
      end else begin
        gaps++;
        stalled = 1'b0;
        rdy_tx  = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; rdy_tx = 1'b1; chan = rand_chan();
    s_start = 1'b1; s_rdy = 1'b1; s_chan = 16'h5A5A;
    repeat (3) @(negedge clk);
    total++; if (d_tx !== 8'h00) $display("FAIL reset_d_tx: got %h want 00", d_tx); else passed++;
    total++; if (vld_tx !== 1'b0) $display("FAIL reset_vld: got %b want 0", vld_tx); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (s_vld !== 1'b0) $display("FAIL reset_small_vld: got %b want 0", s_vld); else passed++;
    rst = 1'b0; start = 1'b0; s_start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || vld_tx !== 1'b0)
      $display("FAIL start_during_reset: busy %b vld %b want 0 0", busy, vld_tx); else passed++;
  endtask

  task automatic test_basic();
    logic [NCH*W-1:0] v;
    logic [7:0] ref10[10] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    int bad = 0, fd;
    v = rand_chan();
    v[31:0] = 32'h0000ABCD;
    kick(v);
    collect(0, 1'b0, 1'b0, 2000);
    build_exp({{(512-NCH*W){1'b0}}, v}, NCH, W, 1'b1);
    for (int i = 0; i < 10; i++) if (i >= got.size() || got[i] !== ref10[i]) bad++;
    total++; if (bad != 0) $display("FAIL basic_first10: %0d wrong bytes, want 0", bad); else passed++;
    total++; if (got.size() != 160) $display("FAIL basic_count: got %0d want 160", got.size()); else passed++;
    fd = first_diff();
    total++; if (fd != -1) $display("FAIL basic_stream: first diff %0d (got %0d bytes, want %0d)", fd, got.size(), exp_q.size()); else passed++;
    total++; if (dones != 1) $display("FAIL basic_done: got %0d pulses want 1", dones); else passed++;
    total++; if (gaps != 0) $display("FAIL basic_gaps: got %0d idle cycles want 0", gaps); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0 || vld_tx !== 1'b0)
      $display("FAIL basic_after: done %b busy %b vld %b want 0 0 0", done, busy, vld_tx); else passed++;
  endtask

  task automatic test_backpressure();
    logic [NCH*W-1:0] v;
    int fd;
    v = rand_chan();
    kick(v);
    collect(2, 1'b0, 1'b0, 2000);
    build_exp({{(512-NCH*W){1'b0}}, v}, NCH, W, 1'b1);
    total++; if (stall_cycles != 5) $display("FAIL stall_len: got %0d want 5", stall_cycles); else passed++;
    total++; if (stall_bad != 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad); else passed++;
    fd = first_diff();
    total++; if (fd != -1) $display("FAIL stall_stream: first diff %0d want -1", fd); else passed++;
    v = rand_chan();
    kick(v);
    collect(1, 1'b0, 1'b0, 3000);
    build_exp({{(512-NCH*W){1'b0}}, v}, NCH, W, 1'b1);
    fd = first_diff();
    total++; if (fd != -1 || dones != 1) $display("FAIL random_rdy_stream: diff %0d dones %0d want -1 1", fd, dones); else passed++;
    total++; if (stall_bad != 0) $display("FAIL random_rdy_hold: got %0d want 0", stall_bad); else passed++;
  endtask

  task automatic test_snapshot();
    logic [NCH*W-1:0] v;
    logic [7:0] ref8[8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    int bad = 0, fd;
    v = rand_chan();
    v[31:0] = 32'h12345678;
    kick(v);
    collect(1, 1'b0, 1'b1, 3000);
    build_exp({{(512-NCH*W){1'b0}}, v}, NCH, W, 1'b1);
    for (int i = 0; i < 8; i++) if (i >= got.size() || got[i] !== ref8[i]) bad++;
    total++; if (bad != 0) $display("FAIL snapshot_first8: %0d wrong bytes want 0", bad); else passed++;
    fd = first_diff();
    total++; if (fd != -1) $display("FAIL snapshot_stream: first diff %0d want -1", fd); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [NCH*W-1:0] v;
    int n = 0, fd;
    kick(rand_chan());
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(negedge clk);
      start  = 1'b0;
      rdy_tx = 1'b1;
      if (vld_tx) n++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (vld_tx !== 1'b0 || busy !== 1'b0 || d_tx !== 8'h00)
      $display("FAIL midreset_async: vld %b busy %b d %h want 0 0 00", vld_tx, busy, d_tx); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (vld_tx !== 1'b0 || busy !== 1'b0)
      $display("FAIL midreset_quiet: vld %b busy %b want 0 0", vld_tx, busy); else passed++;
    v = rand_chan();
    kick(v);
    collect(1, 1'b0, 1'b0, 3000);
    build_exp({{(512-NCH*W){1'b0}}, v}, NCH, W, 1'b1);
    total++; if (got.size() == 0 || got[0] !== exp_q[0])
      $display("FAIL midreset_first: got %h want %h", (got.size() > 0) ? got[0] : 8'h00, exp_q[0]); else passed++;
    fd = first_diff();
    total++; if (fd != -1 || dones != 1) $display("FAIL midreset_stream: diff %0d dones %0d want -1 1", fd, dones); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [NCH*W-1:0] v;
    int fd;
    v = rand_chan();
    kick(v);
    collect(1, 1'b1, 1'b0, 3000);
    build_exp({{(512-NCH*W){1'b0}}, v}, NCH, W, 1'b1);
    total++; if (got.size() != 160) $display("FAIL held_start_count: got %0d want 160", got.size()); else passed++;
    fd = first_diff();
    total++; if (fd != -1) $display("FAIL held_start_stream: first diff %0d want -1", fd); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL held_start_single_done: done %b busy %b want 0 0", done, busy); else passed++;
    v = rand_chan();
    kick(v);
    collect(0, 1'b0, 1'b0, 2000);
    build_exp({{(512-NCH*W){1'b0}}, v}, NCH, W, 1'b1);
    fd = first_diff();
    total++; if (fd != -1 || dones != 1) $display("FAIL second_dump: diff %0d dones %0d want -1 1", fd, dones); else passed++;
  endtask

  task automatic test_small_params();
    logic [7:0] ref7[7] = '{8'h31, 8'h46, 8'h20, 8'h41, 8'h30, 8'h0D, 8'h0A};
    int bad, fd, sd;
    for (int run = 0; run < 3; run++) begin
      got.delete();
      sd = 0;
      @(negedge clk);
      s_chan  = (run == 0) ? 16'hA01F : 16'($urandom);
      s_start = 1'b1;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        s_start = 1'b0;
        if (s_done === 1'b1) begin
          sd++;
          break;
        end
        if (s_vld === 1'b1) begin
          s_rdy = (run == 0) ? 1'b1 : ($urandom_range(0, 1) != 0);
          if (s_rdy) got.push_back(s_d);
        end
      end
      s_rdy = 1'b1;
      build_exp({496'b0, s_chan}, 2, 8, 1'b0);
      if (run == 0) begin
        bad = 0;
        for (int i = 0; i < 7; i++) if (i >= got.size() || got[i] !== ref7[i]) bad++;
        total++; if (bad != 0 || got.size() != 7)
          $display("FAIL small_literal: %0d wrong, %0d bytes, want 0 wrong 7 bytes", bad, got.size()); else passed++;
      end
      fd = first_diff();
      total++; if (fd != -1 || sd != 1)
        $display("FAIL small_stream_%0d: diff %0d dones %0d want -1 1", run, fd, sd); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    test_small_params();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
